// File: rtl/decode_stage_pkg.sv
// ---------------------------------------------------------------------------
// decode_stage_pkg
// Shared definitions for the decode stage: register-file geometry, instruction
// field positions, opcode/funct constants, the decoded control bundle and small
// helper functions for field extraction, immediate extension and operand
// selection (register-file data versus writeback forwarding).
// ---------------------------------------------------------------------------
package decode_stage_pkg;

    // Register file geometry
    localparam int REG_ADDR = 5;
    localparam int REG_SIZE = 32;
    localparam int INSTR_W  = 32;

    // Instruction field bit positions
    localparam int OP_MSB    = 31;
    localparam int OP_LSB    = 26;
    localparam int RS_MSB    = 25;
    localparam int RS_LSB    = 21;
    localparam int RT_MSB    = 20;
    localparam int RT_LSB    = 16;
    localparam int RD_MSB    = 15;
    localparam int RD_LSB    = 11;
    localparam int FUNCT_MSB = 5;
    localparam int FUNCT_LSB = 0;
    localparam int IMM_MSB   = 15;
    localparam int IMM_LSB   = 0;

    // Opcodes recognised by the decoder
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes (passed through to execute untouched)
    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_AND = 6'h24;
    localparam logic [5:0] FUNCT_OR  = 6'h25;
    localparam logic [5:0] FUNCT_SLT = 6'h2A;

    // Decoded control bundle carried into ID/EX
    typedef struct packed {
        logic regwrite;
        logic memread;
        logic memwrite;
        logic branch;
        logic illegal;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE = 5'b00000;

    function automatic logic [5:0] instr_op(input logic [INSTR_W-1:0] instr);
        return instr[OP_MSB:OP_LSB];
    endfunction

    function automatic logic [REG_ADDR-1:0] instr_rs(input logic [INSTR_W-1:0] instr);
        return instr[RS_MSB:RS_LSB];
    endfunction

    function automatic logic [REG_ADDR-1:0] instr_rt(input logic [INSTR_W-1:0] instr);
        return instr[RT_MSB:RT_LSB];
    endfunction

    function automatic logic [REG_ADDR-1:0] instr_rd(input logic [INSTR_W-1:0] instr);
        return instr[RD_MSB:RD_LSB];
    endfunction

    function automatic logic [5:0] instr_funct(input logic [INSTR_W-1:0] instr);
        return instr[FUNCT_MSB:FUNCT_LSB];
    endfunction

    // 16-bit immediate sign-extended to a full word
    function automatic logic [31:0] instr_imm_sext(input logic [INSTR_W-1:0] instr);
        return {{16{instr[IMM_MSB]}}, instr[IMM_MSB:IMM_LSB]};
    endfunction

    // Operand source: r0 is hard-wired to zero and never forwarded; otherwise a
    // writeback to the same address in this cycle wins over the stale RF data.
    // Only addresses are compared, never data values.
    function automatic logic [REG_SIZE-1:0] select_operand(
        input logic [REG_ADDR-1:0] addr,
        input logic [REG_SIZE-1:0] rf_data,
        input logic                bypass_en,
        input logic                wb_regwrite,
        input logic [REG_ADDR-1:0] wb_wreg,
        input logic [REG_SIZE-1:0] wb_wdata
    );
        logic [REG_SIZE-1:0] result;
        if (addr == 5'd0) begin
            result = 32'h0000_0000;
        end else if (bypass_en && wb_regwrite && (wb_wreg != 5'd0) && (wb_wreg == addr)) begin
            result = wb_wdata;
        end else begin
            result = rf_data;
        end
        return result;
    endfunction

endpackage

// File: rtl/decode_stage_hazard_detect.sv
// ---------------------------------------------------------------------------
// hazard_detect
// Purely combinational load-use hazard comparator.
// Ports:
//   rs, rt      : source register addresses of the instruction in IF/ID
//   uses_rt     : instruction actually reads rt as a source
//   valid       : IF/ID entry holds a real instruction
//   ex_memread  : instruction in ID/EX is a load
//   ex_rd       : destination of the instruction in ID/EX
//   hazard      : IF/ID must wait one cycle for the load result
// ---------------------------------------------------------------------------
module hazard_detect
    import decode_stage_pkg::*;
(
    input  logic [REG_ADDR-1:0] rs,
    input  logic [REG_ADDR-1:0] rt,
    input  logic                uses_rt,
    input  logic                valid,
    input  logic                ex_memread,
    input  logic [REG_ADDR-1:0] ex_rd,
    output logic                hazard
);

    logic rs_match_s;
    logic rt_match_s;

    // Address-only comparisons; a load into r0 never produces a usable value
    // so it can never be a dependency.
    always_comb begin
        rs_match_s = (ex_rd == rs);
        rt_match_s = (ex_rd == rt) && uses_rt;
        if (valid && ex_memread && (ex_rd != 5'd0)) begin
            hazard = rs_match_s || rt_match_s;
        end else begin
            hazard = 1'b0;
        end
    end

endmodule

// File: rtl/decode_stage.sv
// ---------------------------------------------------------------------------
// decode_stage
// Instruction decode stage: IF/ID latch, field decoder, register-file read with
// optional writeback forwarding, load-use stall generation and ID/EX register.
// Ports:
//   clk, reset                  : clock, synchronous active-high reset
//   valid_in, instr_in, pc_in   : fetch-side instruction into IF/ID
//   stall_out                   : combinational; fetch holds its outputs when high
//   flush                       : branch-redirect kill of IF/ID and ID/EX
//   rreg1, rreg2 / rdata1, rdata2 : combinational register-file read port
//   wb_regwrite, wb_wreg, wb_wdata: writeback bus, observed for forwarding
//   ex_memread, ex_rd           : load in ID/EX consumer, for load-use detection
//   id_*                        : registered ID/EX contents
// ---------------------------------------------------------------------------
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int WB_BYPASS = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                valid_in,
    input  logic [31:0]         instr_in,
    input  logic [31:0]         pc_in,
    output logic                stall_out,
    input  logic                flush,
    output logic [REG_ADDR-1:0] rreg1,
    output logic [REG_ADDR-1:0] rreg2,
    input  logic [REG_SIZE-1:0] rdata1,
    input  logic [REG_SIZE-1:0] rdata2,
    input  logic                wb_regwrite,
    input  logic [REG_ADDR-1:0] wb_wreg,
    input  logic [REG_SIZE-1:0] wb_wdata,
    input  logic                ex_memread,
    input  logic [REG_ADDR-1:0] ex_rd,
    output logic                id_valid,
    output logic [31:0]         id_pc,
    output logic [5:0]          id_op,
    output logic [5:0]          id_funct,
    output logic [REG_SIZE-1:0] id_rs_data,
    output logic [REG_SIZE-1:0] id_rt_data,
    output logic [31:0]         id_imm,
    output logic [REG_ADDR-1:0] id_rd,
    output logic                id_regwrite,
    output logic                id_memread,
    output logic                id_memwrite,
    output logic                id_branch,
    output logic                id_illegal
);

    localparam bit BYPASS_EN = (WB_BYPASS != 0);

    // IF/ID latch
    logic                ifid_valid_r;
    logic [31:0]         ifid_instr_r;
    logic [31:0]         ifid_pc_r;

    // Decoded view of the IF/ID contents
    logic [5:0]          op_s;
    logic [5:0]          funct_s;
    logic [REG_ADDR-1:0] rs_s;
    logic [REG_ADDR-1:0] rt_s;
    logic [REG_ADDR-1:0] rd_s;
    logic [31:0]         imm_s;
    logic [REG_ADDR-1:0] dest_s;
    logic                uses_rt_s;
    ctrl_t               ctrl_s;
    logic [REG_SIZE-1:0] rs_data_s;
    logic [REG_SIZE-1:0] rt_data_s;

    logic                hazard_s;
    logic                stall_s;
    logic                bubble_s;

    assign op_s    = instr_op(ifid_instr_r);
    assign funct_s = instr_funct(ifid_instr_r);
    assign rs_s    = instr_rs(ifid_instr_r);
    assign rt_s    = instr_rt(ifid_instr_r);
    assign rd_s    = instr_rd(ifid_instr_r);
    assign imm_s   = instr_imm_sext(ifid_instr_r);

    // The read port always follows IF/ID, valid or not.
    assign rreg1 = rs_s;
    assign rreg2 = rt_s;

    // Opcode decode: control bits, destination register and rt usage
    always_comb begin
        ctrl_s    = CTRL_NONE;
        dest_s    = 5'd0;
        uses_rt_s = 1'b0;
        case (op_s)
            OP_RTYPE: begin
                ctrl_s.regwrite = 1'b1;
                dest_s          = rd_s;
                uses_rt_s       = 1'b1;
            end
            OP_ADDI: begin
                ctrl_s.regwrite = 1'b1;
                dest_s          = rt_s;
            end
            OP_LW: begin
                ctrl_s.regwrite = 1'b1;
                ctrl_s.memread  = 1'b1;
                dest_s          = rt_s;
            end
            OP_SW: begin
                ctrl_s.memwrite = 1'b1;
                uses_rt_s       = 1'b1;
            end
            OP_BEQ: begin
                ctrl_s.branch = 1'b1;
                uses_rt_s     = 1'b1;
            end
            default: begin
                ctrl_s.illegal = 1'b1;
            end
        endcase
    end

    // Operand selection with writeback forwarding
    always_comb begin
        rs_data_s = select_operand(rs_s, rdata1, BYPASS_EN, wb_regwrite, wb_wreg, wb_wdata);
        rt_data_s = select_operand(rt_s, rdata2, BYPASS_EN, wb_regwrite, wb_wreg, wb_wdata);
    end

    hazard_detect u_hazard_detect (
        .rs         (rs_s),
        .rt         (rt_s),
        .uses_rt    (uses_rt_s),
        .valid      (ifid_valid_r),
        .ex_memread (ex_memread),
        .ex_rd      (ex_rd),
        .hazard     (hazard_s)
    );

    // A flush kills the stalled instruction anyway, so it suppresses the stall;
    // reset likewise forces the stall request low.
    assign stall_s   = hazard_s && !flush && !reset;
    assign stall_out = stall_s;

    // ID/EX receives a bubble on flush, on stall, or when IF/ID is empty.
    assign bubble_s = flush || stall_s || !ifid_valid_r;

    // IF/ID latch: reset clears, flush discards, stall holds, otherwise capture
    always_ff @(posedge clk) begin
        if (reset) begin
            ifid_valid_r <= 1'b0;
            ifid_instr_r <= 32'h0000_0000;
            ifid_pc_r    <= 32'h0000_0000;
        end else if (flush) begin
            ifid_valid_r <= 1'b0;
            ifid_instr_r <= 32'h0000_0000;
            ifid_pc_r    <= 32'h0000_0000;
        end else if (stall_s) begin
            ifid_valid_r <= ifid_valid_r;
            ifid_instr_r <= ifid_instr_r;
            ifid_pc_r    <= ifid_pc_r;
        end else begin
            ifid_valid_r <= valid_in;
            ifid_instr_r <= instr_in;
            ifid_pc_r    <= pc_in;
        end
    end

    // ID/EX register: reset and bubbles zero every field, otherwise load decode
    always_ff @(posedge clk) begin
        if (reset || bubble_s) begin
            id_valid    <= 1'b0;
            id_pc       <= 32'h0000_0000;
            id_op       <= 6'h00;
            id_funct    <= 6'h00;
            id_rs_data  <= 32'h0000_0000;
            id_rt_data  <= 32'h0000_0000;
            id_imm      <= 32'h0000_0000;
            id_rd       <= 5'd0;
            id_regwrite <= 1'b0;
            id_memread  <= 1'b0;
            id_memwrite <= 1'b0;
            id_branch   <= 1'b0;
            id_illegal  <= 1'b0;
        end else begin
            id_valid    <= 1'b1;
            id_pc       <= ifid_pc_r;
            id_op       <= op_s;
            id_funct    <= funct_s;
            id_rs_data  <= rs_data_s;
            id_rt_data  <= rt_data_s;
            id_imm      <= imm_s;
            id_rd       <= dest_s;
            id_regwrite <= ctrl_s.regwrite;
            id_memread  <= ctrl_s.memread;
            id_memwrite <= ctrl_s.memwrite;
            id_branch   <= ctrl_s.branch;
            id_illegal  <= ctrl_s.illegal;
        end
    end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter: WB_BYPASS, default 1, enables same-cycle writeback-to-decode forwarding.
REQ-002 Ports: clk, in, 1, single clock; all state updates on its rising edge.
REQ-003 Ports: reset, in, 1, synchronous, active-high.
REQ-004 Ports: valid_in in 1, instr_in in 32, pc_in in 32; fetch-side instruction, captured into the IF/ID latch.
REQ-005 Ports: stall_out out 1, combinational; when high, fetch holds instr_in/pc_in.
REQ-006 Ports: flush in 1, branch-redirect kill of IF/ID and ID/EX contents.
REQ-007 Ports: rreg1, rreg2 out `REG_ADDR; rdata1, rdata2 in `REG_SIZE; combinational register-file read port.
REQ-008 Ports: wb_regwrite in 1, wb_wreg in `REG_ADDR, wb_wdata in `REG_SIZE; writeback bus, observed for bypass.
REQ-009 Ports: ex_memread in 1, ex_rd in `REG_ADDR; load-use hazard inputs from ID/EX consumer.
REQ-010 Ports (registered): id_valid 1, id_pc 32, id_op 6, id_funct 6, id_rs_data/id_rt_data `REG_SIZE, id_imm 32, id_rd `REG_ADDR, id_regwrite, id_memread, id_memwrite, id_branch, id_illegal, each 1 bit.

Function
REQ-011 Field split: op=[31:26], rs=[25:21], rt=[20:16], rd=[15:11], funct=[5:0], imm=[15:0]; `REG_ADDR is 5, `REG_SIZE is 32.
REQ-012 rreg1 = IF/ID rs, rreg2 = IF/ID rt, combinational, regardless of validity.
REQ-013 Decode: op 0x00 -> regwrite, dest rd; 0x08 ADDI -> regwrite, dest rt; 0x23 LW -> regwrite+memread, dest rt; 0x2B SW -> memwrite; 0x04 BEQ -> branch; other -> id_illegal=1, all control bits 0.
REQ-014 id_imm = sign-extended imm[15:0] to 32 bits.
REQ-015 uses_rt is 1 for op 0x00, 0x2B, and 0x04, otherwise 0.
REQ-016 Hazard: set when the IF/ID latch is valid, ex_memread=1, ex_rd!=0, and (ex_rd==rs or (ex_rd==rt and uses_rt)).
REQ-017 stall_out = hazard and not flush.
REQ-018 On a stall edge, the IF/ID latch holds, and a bubble (id_valid=0, all control bits 0) enters ID/EX.
REQ-019 Normal edge: IF/ID <= {valid_in, instr_in, pc_in}; ID/EX <= decode of the old IF/ID contents; one cycle of latency in each register, so an instruction accepted at edge N is visible on id_* after edge N+1.
REQ-020 Flush: on the next edge, the IF/ID valid bit and id_valid clear, all control bits go to 0, and instr_in is discarded; flush has priority over stall and over valid_in.
REQ-021 Bypass (WB_BYPASS=1): when wb_regwrite=1, wb_wreg!=0, and wb_wreg==rreg1 (rreg2), the captured rs (rt) data is wb_wdata instead of rdata1 (rdata2).
REQ-022 Register 0 always reads 0 and is never bypassed.
REQ-023 Write-enable and hazard checks compare register addresses only, never the data values.
REQ-024 An invalid IF/ID entry produces a bubble and never raises a hazard.

Reset
REQ-025 While reset=1 at an edge, the IF/ID valid bit, id_valid, every control bit, and id_illegal are 0.
REQ-026 While reset=1 at an edge, all id_* data fields are 0.
REQ-027 While reset=1, stall_out is 0.
REQ-028 Reset asserted mid-stall or mid-flush discards all in-flight state, and reset has priority over every other input.
REQ-029 The first instruction after reset is accepted on the first edge with reset=0.

Structure
REQ-030 Opcode/funct constants and field bit positions belong in the shared define file, alongside `REG_ADDR/`REG_SIZE.
REQ-031 The hazard comparator is one natural sub-module, hazard_detect: purely combinational, taking rs, rt, uses_rt, valid, ex_memread, ex_rd and producing hazard.
REQ-032 The IF/ID latch, decoder, and ID/EX register remain in decode_stage.

Verification
REQ-033 Reset then ADDI r3,r0,-4 (0x2003FFFC) -> two cycles later: id_valid=1, id_rd=3, id_imm=0xFFFFFFFC, id_regwrite=1.
REQ-034 With LW r5 in EX (ex_memread=1, ex_rd=5) and ADD r6,r5,r1 in IF/ID -> stall_out=1 for one cycle, one bubble (id_valid=0), then ADD issues with the correct rs data.
REQ-035 Stall plus flush asserted together -> stall_out=0, and the next edge gives id_valid=0 with the IF/ID latch invalid.
REQ-036 wb_regwrite=1, wb_wreg=7, wb_wdata=0xDEADBEEF while IF/ID reads rs=7 with rdata1=0x11 -> id_rs_data=0xDEADBEEF; with wb_wreg=0 -> id_rs_data=0x11.
REQ-037 op 0x3F -> id_illegal=1 and all control bits 0; SW with ex_rd==rt and ex_memread=1 -> stall (uses_rt=1).
REQ-038 Reset asserted during a stall -> all id_* outputs 0 and stall_out=0 on that edge.
